alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (req0 = integer pipeline issue, req1 = address/branch unit) using valid/ready handshakes and round-robin arbitration.
- Holds the ALU operands stable for a per-opcode number of cycles, so MULT/DIV can be timed as multi-cycle operations.
- Captures the result and flags, and returns them on a response handshake.
- Sits between the issue logic and the ALU instance. It drives the ALU's opt/a/b inputs and samples its out/zero/negative/carry outputs.

Parameters:
- MULT_CYCLES, 4, EXEC cycles for ALU_MULT (legal range 1..15).
- DIV_CYCLES, 8, EXEC cycles for ALU_DIV (legal range 1..15).
- Opcodes are the ALU_* macros from alu_opts.sv. This block defines no new encodings.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opt  in  4  requester 0 ALU opcode
- req0_a  in  32  requester 0 operand a
- req0_b  in  32  requester 0 operand b
- req1_valid / req1_ready / req1_opt / req1_a / req1_b  same widths and meanings, requester 1
- alu_opt  out  4  to ALU opt
- alu_a  out  32  to ALU a
- alu_b  out  32  to ALU b
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- alu_negative  in  1  ALU negative flag
- alu_carry  in  1  ALU overflow flag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that owns the result (0/1)
- resp_out  out  32  captured result
- resp_zero  out  1  captured zero flag
- resp_negative  out  1  captured negative flag
- resp_carry  out  1  captured overflow flag
- busy  out  1  state != IDLE
- op_count  out  16  completed responses, wraps at 0xFFFF -> 0

Behaviour:
- Reset (synchronous, wins over everything, aborts any in-flight op):
  - state=IDLE; last_grant=1, so req0 wins the first tie.
  - Operand regs, counter, all resp_* and op_count are 0.
  - resp_valid=0, busy=0.
  - reqN_ready=0 while reset is high.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && !reset.
  - Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- IDLE, on accept (valid&&ready):
  - Latch opt/a/b into operand regs and set resp_id = grant and last_grant = grant.
  - Load counter with N-1, where N = MULT_CYCLES for ALU_MULT, DIV_CYCLES for ALU_DIV, else 1.
  - Go to EXEC.
- ALU drive:
  - alu_opt/alu_a/alu_b always come from the operand regs, never directly from the req ports.
  - Values are stable for the whole EXEC period and hold their last values otherwise.
- EXEC:
  - counter!=0: decrement.
  - counter==0: capture alu_out/zero/negative/carry into resp_*, set resp_valid=1, go to RESP.
- Latency: accept at edge T -> resp_valid high from edge T+N+1. A non-MULT/DIV op is visible 2 cycles after accept.
- Divide by zero (ALU_DIV with b==0):
  - Still takes DIV_CYCLES.
  - ALU output is ignored; capture resp_out=0xFFFF_FFFF, resp_zero=0, resp_negative=1, resp_carry=1.
- Unused opcodes: latency 1, result is whatever the ALU returns (0).
- RESP:
  - resp_* hold stable until resp_valid&&resp_ready.
  - On that edge: resp_valid=0, op_count+=1 (wrapping), go to IDLE.
  - No new accept in RESP or EXEC, so the earliest next accept is the cycle after the response handshake.
- resp_ready high before resp_valid: no effect.
- A requester dropping valid before ready: nothing latched, no state change.
- Throughput: one op per N+2 cycles minimum.

Test Plan:
1. Reset, then req0 ALU_ADD a=5 b=7, resp_ready=1 -> req0_ready high in accept cycle; resp_valid exactly 2 cycles later with resp_out=12, resp_id=0, zero=0, carry=0; op_count=1.
2. req0 and req1 both valid every cycle after reset, ALU_SUB (a=3,b=3) and ALU_OR (a=0xF0,b=0x0F) -> grants alternate 0,1,0,1; responses are resp_out=0 with resp_zero=1 for req0, and 0xFF for req1.
3. ALU_MULT a=6 b=7, MULT_CYCLES=4 -> alu_a/alu_b held at 6/7 for 4 cycles; resp_valid at accept+5 with resp_out=42; ALU_ADD a=0x7FFF_FFFF b=1 -> resp_out=0x8000_0000, negative=1, carry=1.
4. ALU_DIV a=100 b=0 -> after DIV_CYCLES+1 cycles, resp_out=0xFFFF_FFFF, negative=1, carry=1; ALU_DIV a=100 b=7 -> resp_out=14.
5. Hold resp_ready=0 for 10 cycles with req1 valid -> resp_* stable, req1_ready=0 and busy=1 throughout; raising resp_ready gives the handshake, and req1 is accepted the next cycle.
6. Assert reset mid-EXEC of ALU_DIV -> next cycle state IDLE, resp_valid=0, busy=0, op_count=0; a following req1 ALU_AND a=0xC b=0xA -> resp_out=0x8, resp_id=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundles the two requester handshakes, the ALU drive/sample
//               bus and the response handshake of alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
  // Requester 0: integer pipeline issue
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_opt;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  // Requester 1: address/branch unit
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_opt;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  // ALU instance
  logic [3:0]  alu_opt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_carry;
  // Response
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_out;
  logic        resp_zero;
  logic        resp_negative;
  logic        resp_carry;
  // Status
  logic        busy;
  logic [15:0] op_count;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_opt, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opt, req1_a, req1_b,
    output req1_ready,
    output alu_opt, alu_a, alu_b,
    input  alu_out, alu_zero, alu_negative, alu_carry,
    output resp_valid, resp_id, resp_out, resp_zero, resp_negative, resp_carry,
    input  resp_ready,
    output busy, op_count
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_opt, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opt, req1_a, req1_b,
    input  req1_ready,
    input  alu_opt, alu_a, alu_b,
    output alu_out, alu_zero, alu_negative, alu_carry,
    input  resp_valid, resp_id, resp_out, resp_zero, resp_negative, resp_carry,
    output resp_ready,
    input  busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters, with per-opcode multi-cycle hold of the operands
//               and a registered response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Opcode encodings of alu_opts.sv; the real header wins if it is read first.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'd1
`endif
`ifndef ALU_AND
`define ALU_AND  4'd2
`endif
`ifndef ALU_OR
`define ALU_OR   4'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR  4'd4
`endif
`ifndef ALU_NOR
`define ALU_NOR  4'd5
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'd6
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'd7
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'd8
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'd9
`endif
`ifndef ALU_MULT
`define ALU_MULT 4'd10
`endif
`ifndef ALU_DIV
`define ALU_DIV  4'd11
`endif

module alu_arbiter #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  wire logic    clk,
  input  wire logic    reset,
  alu_arbiter_if.slave bus
);

  // Counter preload is cycles-1 so that a count of zero marks the final EXEC cycle
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic [3:0]  op_opt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  count;
  logic [3:0]  load;
  logic [3:0]  sel_opt;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        div_by_zero;

  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_out;
  logic        resp_zero;
  logic        resp_negative;
  logic        resp_carry;
  logic [15:0] op_count;

  // Round-robin pick: a lone requester always wins, a tie goes away from the last winner
  always_comb begin
    grant = ~last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = (state == IDLE) && !grant && !reset;
  assign bus.req1_ready = (state == IDLE) &&  grant && !reset;

  assign accept  = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign sel_opt = grant ? bus.req1_opt : bus.req0_opt;
  assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b   : bus.req0_b;

  // Number of extra EXEC cycles for the opcode being accepted
  always_comb begin
    load = 4'd0;
    if (sel_opt == `ALU_MULT) begin
      load = MULT_LOAD;
    end else if (sel_opt == `ALU_DIV) begin
      load = DIV_LOAD;
    end
  end

  // The ALU's own divide-by-zero result is replaced by a fixed saturated pattern
  assign div_by_zero = (op_opt == `ALU_DIV) && (op_b == 32'd0);

  // Main sequencer: accept in IDLE, count down in EXEC, hold result in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      op_opt        <= 4'd0;
      op_a          <= 32'd0;
      op_b          <= 32'd0;
      count         <= 4'd0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_out      <= 32'd0;
      resp_zero     <= 1'b0;
      resp_negative <= 1'b0;
      resp_carry    <= 1'b0;
      op_count      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_opt     <= sel_opt;
            op_a       <= sel_a;
            op_b       <= sel_b;
            resp_id    <= grant;
            last_grant <= grant;
            count      <= load;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (div_by_zero) begin
              resp_out      <= 32'hFFFF_FFFF;
              resp_zero     <= 1'b0;
              resp_negative <= 1'b1;
              resp_carry    <= 1'b1;
            end else begin
              resp_out      <= bus.alu_out;
              resp_zero     <= bus.alu_zero;
              resp_negative <= bus.alu_negative;
              resp_carry    <= bus.alu_carry;
            end
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_opt       = op_opt;
  assign bus.alu_a         = op_a;
  assign bus.alu_b         = op_b;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_id       = resp_id;
  assign bus.resp_out      = resp_out;
  assign bus.resp_zero     = resp_zero;
  assign bus.resp_negative = resp_negative;
  assign bus.resp_carry    = resp_carry;
  assign bus.op_count      = op_count;
  assign bus.busy          = (state != IDLE);

endmodule

`default_nettype wire
